aes_key_sched: RTL
==================

Name: aes_key_sched

Overview:
- Iterative AES-128/192/256 key-expansion controller.
- Generates the FIPS-197 expanded key at one 32-bit word per cycle, using the shared Rcon/RotWord/SubWord functions from package myfunction.
- Emits round keys 0..Nr as 128-bit words over a valid/ready stream.
- Sits between key load and the round datapath; the round datapath consumes one round key per handshake.

Parameters:
- KEYW, 256, width of the key input bus; fixed for all key lengths.
- IDXW, 4, width of rk_idx; must cover 0..14.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin expansion; sampled only in IDLE
- key_len  in  2  key length: 2'b00 = 128, 2'b01 = 192, 2'b10 = 256, 2'b11 reserved (treated as 128); sampled with start
- key  in  256  cipher key, MSB-aligned: 128-bit key in [255:128], 192-bit key in [255:64]; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- rk_valid  out  1  rk/rk_idx hold a valid round key
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready
- rk  out  128  round key, word w[4r] in [127:96]
- rk_idx  out  IDXW  round number r of rk
- done  out  1  one-cycle pulse in the cycle the last round key (r = Nr) is accepted

Behaviour:
- Constants: Nk = 4/6/8 and Nr = 10/12/14 for 128/192/256. Total words = 4*(Nr+1) = 44/52/60.
- Reset: FSM returns to IDLE. busy, rk_valid and done are 0; rk and rk_idx are 0. Internal word counter and window are cleared. Reset mid-expansion abandons the sequence without a done pulse.
- FSM states:
  - IDLE -> GEN on start; key and key_len are latched.
  - GEN: produces w[i] each cycle unless stalled.
  - HOLD: the 4-word assembly register is full and the output register is occupied and not being accepted.
  - DRAIN: all words have been produced; wait for the last handshake, then go to IDLE.
- Word rule:
  - i < Nk: w[i] = key word i.
  - Otherwise w[i] = w[i-Nk] ^ t, where t is:
    - SubWord(RotWord(w[i-1])) ^ Rcon(i/Nk) when i mod Nk == 0;
    - SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4;
    - w[i-1] otherwise.
  - A sliding window of the last 8 words feeds the rule; the low Nk entries are used.
  - i mod Nk is tracked by a separate modulo counter; no divider.
- Assembly: words fill a 4-word register. When the 4th word of round r is written, the register moves to rk/rk_idx (rk_valid = 1) on the next edge, provided the output register is empty or is being accepted in the same cycle. Otherwise the FSM goes to HOLD and generation stalls, with no words lost.
- Timing with rk_ready held high, start accepted in cycle 0:
  - w0..w3 produced in cycles 1-4; rk_valid = 1 with rk_idx = 0 in cycle 5.
  - Round r is valid in cycle 4r+5, one round key per 4 cycles.
  - AES-128 last key (r = 10) is valid and accepted in cycle 45, where done pulses; busy falls in cycle 46.
- rk_valid stays high and rk/rk_idx stay stable until accepted. rk_valid drops after acceptance unless the next round key loads in the same cycle.
- start while busy is ignored; key and key_len are not resampled.
- start in the same cycle as the final handshake is ignored. A new start is accepted from the cycle after done.

Decomposition:
- Package myfunction: add typedef enum logic [1:0] key_len_e (KL128, KL192, KL256) and functions nk_of(key_len_e), nr_of(key_len_e).
- Reuse Rcon, RotWord and SubWord from the package unchanged.
- One natural sub-module: aes_key_word, a combinational next-word unit (inputs w[i-Nk], w[i-1], i mod Nk, i/Nk, Nk; output w[i]).
- The FSM, counters, window and output register live in aes_key_sched.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 -> rk_idx 1 = a0fafe1788542cb123a339392a6c7605, rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 45, done in cycle 45, 11 handshakes total.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 round keys, rk_idx 12 = e98ba06f448c773c8ecc720401002202, then done.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 round keys, rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with rk_ready toggled pseudo-randomly and held low for 20 cycles at r = 3 -> same 11 keys in order, rk stable while valid && !ready, no skipped or duplicated rk_idx.
- start re-pulsed with a different key during busy -> ignored, output identical to the first key; rst asserted at r = 5 -> next cycle busy = 0, rk_valid = 0, no done; a fresh start then produces the full correct sequence.
- key_len = 2'b11 -> behaves exactly as the AES-128 vector.

Source files
------------

// File: rtl/myfunction.sv
// Shared AES helpers for key expansion: key-length decode, Nk/Nr lookup,
// and the FIPS-197 S-box, RotWord, SubWord and Rcon primitives.
package myfunction;

  localparam int unsigned WORDW = 32;
  localparam int unsigned RKW   = 128;
  localparam int unsigned CNTW  = 6;

  typedef enum logic [1:0] {
    KL128 = 2'b00,
    KL192 = 2'b01,
    KL256 = 2'b10
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD,
    DRAIN
  } ks_state_e;

  // The reserved encoding 2'b11 falls back to AES-128.
  function automatic key_len_e kl_decode(input logic [1:0] kl);
    case (kl)
      2'b01:   return KL192;
      2'b10:   return KL256;
      default: return KL128;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL192:   return 4'd6;
      KL256:   return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL192:   return 4'd12;
      KL256:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // S-box entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {8'hff - b, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [WORDW-1:0] sub_word(input logic [WORDW-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [WORDW-1:0] rot_word(input logic [WORDW-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [WORDW-1:0] rcon(input logic [3:0] j);
    logic [7:0] rc;
    case (j)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_key_word.sv
// Combinational next-word unit of the AES key expansion: w[i] from
// w[i-Nk], w[i-1] and the position of i within the current Nk block.
module aes_key_word
  import myfunction::*;
(
  input  logic [WORDW-1:0] w_nk,
  input  logic [WORDW-1:0] w_prev,
  input  logic [2:0]       idx_mod,
  input  logic [3:0]       idx_div,
  input  logic [3:0]       nk,
  output logic [WORDW-1:0] w
);

  logic [WORDW-1:0] t;

  always_comb begin
    t = w_prev;
    if (idx_mod == 3'd0) begin
      t = sub_word(rot_word(w_prev)) ^ rcon(idx_div);
    end else if (nk == 4'd8 && idx_mod == 3'd4) begin
      t = sub_word(w_prev);
    end
    w = w_nk ^ t;
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key scheduler: one expanded word per cycle,
// round keys handed out as 128-bit words over a valid/ready stream.
module aes_key_sched
  import myfunction::*;
#(
  parameter int unsigned KEYW = 256,
  parameter int unsigned IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      key_len,
  input  logic [KEYW-1:0] key,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [RKW-1:0]  rk,
  output logic [IDXW-1:0] rk_idx,
  output logic            done
);

  ks_state_e        state_q, state_d;
  logic [KEYW-1:0]  key_q;
  key_len_e         kl_q;
  logic [CNTW-1:0]  cnt_q;
  logic [2:0]       mod_q;
  logic [3:0]       div_q;
  logic [WORDW-1:0] win_q [8];
  logic [WORDW-1:0] asm_q [4];
  logic [3:0]       nk, nr;
  logic [CNTW-1:0]  total;
  logic             last_word, accept, out_free;
  logic [WORDW-1:0] key_word, rule_word, w_new;
  logic             gen_c, load_gen_c, load_hold_c;

  assign nk        = nk_of(kl_q);
  assign nr        = nr_of(kl_q);
  assign total     = CNTW'({nr, 2'b00}) + CNTW'(4);
  assign last_word = (cnt_q == total - CNTW'(1));
  assign accept    = rk_valid && rk_ready;
  assign out_free  = !rk_valid || rk_ready;
  assign key_word  = key_q[{~cnt_q[2:0], 5'b00000} +: WORDW];
  assign w_new     = (cnt_q < CNTW'(nk)) ? key_word : rule_word;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && accept;

  aes_key_word u_word (
    .w_nk    (win_q[3'(nk - 4'd1)]),
    .w_prev  (win_q[0]),
    .idx_mod (mod_q),
    .idx_div (div_q),
    .nk      (nk),
    .w       (rule_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A full assembly register with a blocked output parks in HOLD.
  always_comb begin
    state_d     = state_q;
    gen_c       = 1'b0;
    load_gen_c  = 1'b0;
    load_hold_c = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = GEN;
      GEN: begin
        gen_c = 1'b1;
        if (cnt_q[1:0] == 2'd3) begin
          if (out_free) begin
            load_gen_c = 1'b1;
            if (last_word) state_d = DRAIN;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (rk_ready) begin
          load_hold_c = 1'b1;
          state_d     = (cnt_q == total) ? DRAIN : GEN;
        end
      end
      DRAIN: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      kl_q     <= KL128;
      cnt_q    <= '0;
      mod_q    <= '0;
      div_q    <= '0;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      for (int k = 0; k < 4; k++) asm_q[k] <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        key_q <= key;
        kl_q  <= kl_decode(key_len);
        cnt_q <= '0;
        mod_q <= '0;
        div_q <= '0;
      end
      // i mod Nk and i / Nk advance together, avoiding a divider.
      if (gen_c) begin
        for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
        win_q[0]          <= w_new;
        asm_q[cnt_q[1:0]] <= w_new;
        cnt_q             <= cnt_q + CNTW'(1);
        if (mod_q == 3'(nk - 4'd1)) begin
          mod_q <= '0;
          div_q <= div_q + 4'd1;
        end else begin
          mod_q <= mod_q + 3'd1;
        end
      end
      if (load_gen_c) begin
        rk       <= {asm_q[0], asm_q[1], asm_q[2], w_new};
        rk_idx   <= IDXW'(cnt_q[5:2]);
        rk_valid <= 1'b1;
      end else if (load_hold_c) begin
        rk       <= {asm_q[0], asm_q[1], asm_q[2], asm_q[3]};
        rk_idx   <= rk_idx + IDXW'(1);
        rk_valid <= 1'b1;
      end else if (accept) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule
